// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - layer pass sequencer for the neuron processing unit
module layer_sequencer #(
  parameter int NUM_NEURONS = 4,
  parameter int PIPE_LAT    = 3,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             ld_in,
  output logic             en_reg,
  output logic [IDX_W-1:0] w_idx,
  output logic             res_we,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [2:0]          state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_w_q, last_w_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]    pidx_q [PIPE_LAT];
  logic [IDX_W-1:0]    pidx_d [PIPE_LAT];
  logic                issue;
  logic                tail_vld;
  logic [IDX_W-1:0]    tail_idx;

  assign tail_vld = vld_q[PIPE_LAT-1];
  assign tail_idx = pidx_q[PIPE_LAT-1];

  always_comb begin
    issue    = (state_q == S_ISSUE) && !hold;
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_w_d = last_w_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_ISSUE;
        cnt_d   = '0;
      end
      S_ISSUE: begin
        if (!hold) begin
          last_w_d = cnt_q;
          // The counter parks on the terminal index instead of wrapping.
          if (cnt_q == LAST_IDX) state_d = S_DRAIN;
          else                   cnt_d   = cnt_q + IDX_W'(1);
        end
      end
      S_DRAIN: if (tail_vld && (tail_idx == LAST_IDX)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight tracker: shifts every cycle, so a write lands PIPE_LAT cycles after its issue.
  always_comb begin
    vld_d     = {vld_q[PIPE_LAT-2:0], issue};
    pidx_d[0] = cnt_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pidx_d[i] = pidx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_w_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pidx_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_w_q <= last_w_d;
      vld_q    <= vld_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pidx_q[i] <= pidx_d[i];
      end
    end
  end

  // Outputs are gated by rst so they read zero for the whole time reset is held.
  assign ld_in   = rst && (state_q == S_LOAD);
  assign en_reg  = rst && issue;
  assign w_idx   = !rst ? '0 : (issue ? cnt_q : last_w_q);
  assign res_we  = rst && tail_vld;
  assign res_idx = (rst && tail_vld) ? tail_idx : '0;
  assign busy    = rst && (state_q != S_IDLE);
  assign done    = rst && (state_q == S_FIN);

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_NEURONS, default 4, meaning neurons per layer pass (1..16).
REQ-002 The module SHALL have parameter PIPE_LAT, default 3, meaning cycles from the en_reg issue cycle to a valid processing-unit result (2..8).
REQ-003 The module SHALL have parameter IDX_W, default 4, meaning the width of neuron index outputs.
REQ-004 The module SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: request one layer pass; sampled only in IDLE.
REQ-007 The module SHALL have port hold, input, 1 bit: stall new issues during ISSUE.
REQ-008 The module SHALL have port ld_in, output, 1 bit: load the activation registers A1..A4.
REQ-009 The module SHALL have port en_reg, output, 1 bit: drives enReg of the processing unit (capture products).
REQ-010 The module SHALL have port w_idx, output, IDX_W bits: neuron index selecting W1..W4 from weight storage.
REQ-011 The module SHALL have port res_we, output, 1 bit: write strobe for the result buffer.
REQ-012 The module SHALL have port res_idx, output, IDX_W bits: result buffer write address.
REQ-013 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle pulse at the end of a pass.

Function
REQ-015 The module SHALL implement states IDLE, LOAD, ISSUE, DRAIN and FIN as a registered FSM.
REQ-016 IDLE SHALL go to LOAD on the cycle after start=1 is sampled; otherwise it SHALL stay in IDLE.
REQ-017 LOAD SHALL last exactly one cycle with ld_in=1, then go to ISSUE with the issue counter at 0.
REQ-018 In ISSUE with hold=0, the module SHALL drive en_reg=1 and w_idx=issue counter, then increment the counter.
REQ-019 In ISSUE with hold=1, the module SHALL drive en_reg=0, hold the counter and issue nothing; w_idx SHALL keep its last value.
REQ-020 After issuing index NUM_NEURONS-1, the module SHALL go to DRAIN; hold SHALL be ignored outside ISSUE.
REQ-021 The module SHALL track in-flight issues with a PIPE_LAT-deep valid/index shift register that advances every cycle, independent of hold and state.
REQ-022 For an issue in cycle t, the module SHALL drive res_we=1 and res_idx=that index in cycle t+PIPE_LAT, exactly once per neuron.
REQ-023 Write order SHALL equal issue order, and indices 0..NUM_NEURONS-1 SHALL each be written once per pass.
REQ-024 DRAIN SHALL go to FIN in the cycle after the final res_we.
REQ-025 FIN SHALL assert done=1 for one cycle, then return to IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 start=1 in the FIN cycle SHALL NOT be captured; a new pass SHALL require start=1 in IDLE.
REQ-028 With no hold, a pass SHALL take 1 (LOAD) + NUM_NEURONS + PIPE_LAT + 1 (FIN) cycles from LOAD entry to the done cycle inclusive.
REQ-029 Index counters SHALL NOT wrap; NUM_NEURONS-1 SHALL be the terminal value.
REQ-030 NUM_NEURONS=1 SHALL go LOAD -> ISSUE (1 cycle) -> DRAIN.

Reset
REQ-031 When rst=0 at a rising edge, the module SHALL enter IDLE and clear the counter and shift register.
REQ-032 While rst=0, outputs ld_in, en_reg, res_we, busy and done SHALL be 0, and w_idx and res_idx SHALL be 0.
REQ-033 Reset mid-pass SHALL abort the pass, with no res_we after reset and none from pre-reset issues.
REQ-034 start held high through reset release SHALL begin a pass only if sampled in IDLE after rst=1.

Verification
REQ-035 Basic pass (defaults): start pulse -> ld_in in cycle 1; en_reg with w_idx 0,1,2,3 in cycles 2-5; res_we with res_idx 0,1,2,3 in cycles 5-8; done in cycle 9; busy low in cycle 10.
REQ-036 Hold: hold=1 during issue cycles 3-4 -> w_idx sequence 0,(stall),(stall),1,2,3; res_we exactly 3 cycles after each en_reg; 4 writes total; done 2 cycles later than REQ-035.
REQ-037 Mid-pass reset: rst=0 in the cycle after w_idx=2 issues -> no res_we afterwards; all outputs 0; next start runs a clean full pass.
REQ-038 Busy start: start=1 held continuously -> passes back-to-back with one IDLE cycle between done and the next ld_in; never two ld_in within one pass.
REQ-039 Parameter corners: NUM_NEURONS=1, PIPE_LAT=2 -> one en_reg, res_we 2 cycles later with res_idx=0, then done; NUM_NEURONS=16 -> indices 0..15 each written exactly once.
